// File: rtl/fib_controller.sv
// Control FSM for the recursive-Fibonacci datapath: walks the call tree using an explicit stack
// of {res, n, f} frames and leaves fib(n) (fib(0)=fib(1)=1) in the datapath ret register.
module fib_controller #(
  parameter int unsigned WORDSIZE = 8,
  parameter int unsigned MAX_N    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WORDSIZE-1:0] n_arg,
  input  logic                ready,
  input  logic                lt,
  input  logic                gt,
  input  logic                eq,
  input  logic [WORDSIZE-1:0] f,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                push,
  output logic                pop,
  output logic                addsub,
  output logic                ress,
  output logic                ns,
  output logic                fs,
  output logic                resld,
  output logic                retld,
  output logic                nld,
  output logic                fld,
  output logic                resrst,
  output logic                retrst,
  output logic                nrst,
  output logic                frst,
  output logic [1:0]          rets,
  output logic [1:0]          ss,
  output logic [1:0]          addls,
  output logic [1:0]          addrs
);

  localparam logic [WORDSIZE-1:0] MaxN = WORDSIZE'(MAX_N);

  typedef enum logic [4:0] {
    StDrain, StIdle, StLdinc, StLdn, StCall, StPushr, StPushn, StPushf, StDec,
    StRet, StPopf, StPopn, StPopr, StDisp, StSave, StIncf, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [WORDSIZE-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  // The comparator's gt flag carries no information beyond lt/eq.
  logic unused_gt;
  assign unused_gt = gt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StDrain;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    addsub  = 1'b0;
    ress    = 1'b0;
    ns      = 1'b0;
    fs      = 1'b0;
    resld   = 1'b0;
    retld   = 1'b0;
    nld     = 1'b0;
    fld     = 1'b0;
    resrst  = 1'b0;
    retrst  = 1'b0;
    nrst    = 1'b0;
    frst    = 1'b0;
    rets    = 2'd0;
    ss      = 2'd0;
    addls   = 2'd0;
    addrs   = 2'd0;

    case (state_q)
      StDrain: begin
        nrst   = 1'b1;
        frst   = 1'b1;
        resrst = 1'b1;
        retrst = 1'b1;
        pop    = ~ready;
        if (ready) state_d = StIdle;
      end
      StIdle, StDone: begin
        busy = 1'b0;
        done = (state_q == StDone);
        if (start) begin
          if (n_arg > MaxN) begin
            err_d = 1'b1;
          end else begin
            cnt_d   = n_arg;
            frst    = 1'b1;
            state_d = StLdinc;
          end
        end
      end
      // n is built by counting f up to n_arg, since n only loads from the ALU or the stack.
      StLdinc: begin
        if (cnt_q != '0) begin
          fld   = 1'b1;
          cnt_d = cnt_q - WORDSIZE'(1);
        end else begin
          state_d = StLdn;
        end
      end
      StLdn: begin
        nld     = 1'b1;
        frst    = 1'b1;
        state_d = StCall;
      end
      StCall: begin
        if (lt || eq) begin
          retld   = 1'b1;
          state_d = StRet;
        end else begin
          state_d = StPushr;
        end
      end
      StPushr: begin
        push    = 1'b1;
        ss      = 2'd2;
        state_d = StPushn;
      end
      StPushn: begin
        push    = 1'b1;
        ss      = 2'd1;
        state_d = StPushf;
      end
      StPushf: begin
        push    = 1'b1;
        ss      = 2'd0;
        state_d = StDec;
      end
      // First child is n-1; the re-pushed frame (f=1) descends into n-2.
      StDec: begin
        addls   = 2'd1;
        addrs   = (f == '0) ? 2'd2 : 2'd3;
        addsub  = 1'b1;
        nld     = 1'b1;
        frst    = 1'b1;
        state_d = StCall;
      end
      StRet: begin
        state_d = ready ? StDone : StPopf;
      end
      StPopf: begin
        pop     = 1'b1;
        fs      = 1'b1;
        fld     = 1'b1;
        state_d = StPopn;
      end
      StPopn: begin
        pop     = 1'b1;
        ns      = 1'b1;
        nld     = 1'b1;
        state_d = StPopr;
      end
      StPopr: begin
        pop     = 1'b1;
        ress    = 1'b1;
        resld   = 1'b1;
        state_d = StDisp;
      end
      StDisp: begin
        if (f == '0) begin
          state_d = StSave;
        end else begin
          addls   = 2'd2;
          addrs   = 2'd1;
          rets    = 2'd1;
          retld   = 1'b1;
          state_d = StRet;
        end
      end
      StSave: begin
        addrs   = 2'd1;
        resld   = 1'b1;
        state_d = StIncf;
      end
      StIncf: begin
        fld     = 1'b1;
        state_d = StPushr;
      end
      default: state_d = StDrain;
    endcase
  end

endmodule

// File: tb/tb_fib_controller.sv
// Closes the loop around fib_controller with a behavioural datapath (stack, n/f/res/ret, ALU)
// and compares results against an iterative Fibonacci reference.
module tb_fib_controller;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] n_arg = '0;

  logic ready, lt, gt, eq;
  logic [W-1:0] f_r = '0, n_r = '0, res_r = '0, ret_r = '0;
  logic busy, done, err, push, pop, addsub, ress, ns, fs;
  logic resld, retld, nld, fld, resrst, retrst, nrst, frst;
  logic [1:0] rets, ss, addls, addrs;

  // Second instance only checks that MAX_N moves the rejection boundary.
  logic start13 = 1'b0;
  logic [W-1:0] n13 = '0;
  logic busy13, done13, err13;
  logic [13:0] u13;
  logic [7:0] u13s;

  always #5 clk = ~clk;

  fib_controller #(.WORDSIZE(W), .MAX_N(12)) dut (
    .clk(clk), .rst(rst), .start(start), .n_arg(n_arg), .ready(ready),
    .lt(lt), .gt(gt), .eq(eq), .f(f_r), .busy(busy), .done(done), .err(err),
    .push(push), .pop(pop), .addsub(addsub), .ress(ress), .ns(ns), .fs(fs),
    .resld(resld), .retld(retld), .nld(nld), .fld(fld), .resrst(resrst),
    .retrst(retrst), .nrst(nrst), .frst(frst), .rets(rets), .ss(ss),
    .addls(addls), .addrs(addrs)
  );

  fib_controller #(.WORDSIZE(W), .MAX_N(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .n_arg(n13), .ready(1'b1),
    .lt(1'b0), .gt(1'b0), .eq(1'b0), .f(8'd0), .busy(busy13), .done(done13), .err(err13),
    .push(u13[0]), .pop(u13[1]), .addsub(u13[2]), .ress(u13[3]), .ns(u13[4]), .fs(u13[5]),
    .resld(u13[6]), .retld(u13[7]), .nld(u13[8]), .fld(u13[9]), .resrst(u13[10]),
    .retrst(u13[11]), .nrst(u13[12]), .frst(u13[13]), .rets(u13s[1:0]), .ss(u13s[3:2]),
    .addls(u13s[5:4]), .addrs(u13s[7:6])
  );

  // ---------------- behavioural datapath ----------------
  logic [W-1:0] stk [0:63];
  int sp = 0, push_cnt = 0, pop_cnt = 0, viol = 0;
  logic [W-1:0] dout, din, alu_l, alu_r, alu;

  always_comb begin
    dout  = (sp > 0) ? stk[sp-1] : '0;
    ready = (sp == 0);
    lt    = (n_r < 8'd1);
    eq    = (n_r == 8'd1);
    gt    = (n_r > 8'd1);
    din   = (ss == 2'd0) ? f_r : (ss == 2'd1) ? n_r : res_r;
    alu_l = (addls == 2'd1) ? n_r : (addls == 2'd2) ? res_r : 8'd0;
    case (addrs)
      2'd0: alu_r = f_r;
      2'd1: alu_r = ret_r;
      2'd2: alu_r = 8'd1;
      default: alu_r = 8'd2;
    endcase
    alu = addsub ? W'(alu_l - alu_r) : W'(alu_l + alu_r);
  end

  always @(posedge clk) begin
    if ((push && pop) || (int'(ns && nld) + int'(fs && fld) + int'(ress && resld) > 1))
      viol <= viol + 1;
    if (push && sp < 64) begin
      stk[sp]  <= din;
      sp       <= sp + 1;
      push_cnt <= push_cnt + 1;
    end else if (pop && sp > 0) begin
      sp      <= sp - 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (nrst) n_r <= '0;
    else if (nld) n_r <= ns ? dout : alu;
    if (frst) f_r <= '0;
    else if (fld) f_r <= fs ? dout : W'(f_r + 8'd1);
    if (resrst) res_r <= '0;
    else if (resld) res_r <= ress ? dout : alu;
    if (retrst) ret_r <= '0;
    else if (retld) ret_r <= (rets == 2'd0) ? 8'd1 : (rets == 2'd1) ? alu : res_r;
  end

  // ---------------- reference and bookkeeping ----------------
  int passed = 0, total = 0;

  function automatic int ref_fib(input int n);
    int a = 1, b = 1, c;
    for (int i = 2; i <= n; i++) begin
      c = (a + b) % 256;
      a = b;
      b = c;
    end
    return b;
  endfunction

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    n_arg = W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done; reports result, peak stack depth and whether the budget expired.
  task automatic wait_done(output int res, output int max_sp, output bit to);
    to = 1'b1;
    max_sp = sp;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (sp > max_sp) max_sp = sp;
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    res = int'(ret_r);
  endtask

  task automatic run_check(input int n, input string name);
    int res, msp, p0, q0;
    bit to;
    p0 = push_cnt;
    q0 = pop_cnt;
    pulse_start(n);
    wait_done(res, msp, to);
    total++;
    if (to) $display("FAIL %s n=%0d: done not seen within cycle budget", name, n);
    else passed++;
    total++;
    if (res !== ref_fib(n)) $display("FAIL %s n=%0d: result %0d, expected %0d", name, n, res,
                                     ref_fib(n));
    else passed++;
    total++;
    if ((push_cnt - p0) !== (pop_cnt - q0) || sp !== 0)
      $display("FAIL %s n=%0d: pushes %0d pops %0d sp %0d, expected balanced and empty", name, n,
               push_cnt - p0, pop_cnt - q0, sp);
    else passed++;
  endtask

  task automatic test_reset;
    int c;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL reset_status: busy=%b done=%b err=%b, expected 1 0 0", busy, done, err);
    else passed++;
    #1 rst = 1'b0;
    for (c = 0; c < 50 && busy !== 1'b0; c++) @(negedge clk);
    total++;
    if (busy !== 1'b0 || sp !== 0 || ret_r !== 8'd0)
      $display("FAIL reset_idle: busy=%b sp=%0d ret=%0d, expected 0 0 0", busy, sp, ret_r);
    else passed++;
  endtask

  task automatic test_base_cases;
    int p0;
    p0 = push_cnt;
    run_check(0, "fib0");
    total++;
    if (push_cnt !== p0) $display("FAIL fib0_nopush: pushes %0d, expected 0", push_cnt - p0);
    else passed++;
    run_check(1, "fib1");
  endtask

  task automatic test_known;
    int res, msp;
    bit to;
    run_check(5, "fib5");
    run_check(10, "fib10");
    pulse_start(12);
    wait_done(res, msp, to);
    total++;
    if (to || res !== 233) $display("FAIL fib12: result %0d timeout %b, expected 233", res, to);
    else passed++;
    total++;
    if (msp !== 33) $display("FAIL fib12_depth: max stack %0d, expected 33", msp);
    else passed++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) run_check(int'($urandom_range(0, 10)), "random");
  endtask

  task automatic test_err;
    int n, errs, strobes, busys;
    for (int i = 0; i < 3; i++) begin
      n = (i == 0) ? 13 : int'($urandom_range(13, 255));
      errs = 0;
      strobes = 0;
      busys = 0;
      pulse_start(n);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (err === 1'b1) errs++;
        if (busy !== 1'b0) busys++;
        if (push || pop || nld || fld || resld || retld || nrst || frst || resrst || retrst)
          strobes++;
      end
      total++;
      if (errs !== 1 || busys !== 0 || strobes !== 0)
        $display("FAIL err_n%0d: err cycles %0d busy cycles %0d strobe cycles %0d, expected 1 0 0",
                 n, errs, busys, strobes);
      else passed++;
    end
    // MAX_N=13 accepts 13.
    @(posedge clk); #1;
    start13 = 1'b1;
    n13 = 8'd13;
    @(posedge clk); #1;
    start13 = 1'b0;
    @(negedge clk);
    total++;
    if (busy13 !== 1'b1 || err13 !== 1'b0)
      $display("FAIL maxn13_accept: busy=%b err=%b, expected 1 0", busy13, err13);
    else passed++;
  endtask

  task automatic test_mid_reset;
    int c;
    pulse_start(6);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL midrst_drain: busy=%b done=%b, expected 1 0", busy, done);
    else passed++;
    for (c = 0; c < 100 && busy !== 1'b0; c++) @(negedge clk);
    total++;
    if (busy !== 1'b0 || sp !== 0 || done !== 1'b0)
      $display("FAIL midrst_idle: busy=%b sp=%0d done=%b, expected 0 0 0", busy, sp, done);
    else passed++;
    run_check(4, "after_reset");
  endtask

  task automatic test_back_to_back;
    int res, msp;
    bit to;
    pulse_start(7);
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;
    n_arg = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(res, msp, to);
    total++;
    if (to || res !== 21) $display("FAIL busy_start: result %0d timeout %b, expected 21", res, to);
    else passed++;
    // Restart straight out of DONE.
    run_check(8, "from_done");
  endtask

  initial begin
    test_reset();
    test_base_cases();
    test_known();
    test_random();
    test_err();
    test_mid_reset();
    test_back_to_back();
    total++;
    if (viol !== 0) $display("FAIL strobe_rules: %0d violating cycles, expected 0", viol);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
